// File: rtl/psg_multi.sv
// Multi-channel PSG: square tones, shared 17-bit LFSR noise and a per-channel envelope, summed into one mono sample.
// LEVEL is combinational from state and MIX is registered one CE later; bus writes never stall, and CE=0 freezes only the sound state.
module psg_multi #(
   parameter  int CHANNELS = 3,
   parameter  int TONE_W   = 12,
   parameter  int DIV      = 8,
   localparam int MIX_W    = 8 + $clog2(CHANNELS)
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic                    CE,
   input  logic                    BDIR,
   input  logic                    BC,
   input  logic [7:0]              DI,
   output logic [7:0]              DO,
   output logic [5*CHANNELS-1:0]   LEVEL,
   output logic [MIX_W-1:0]        MIX
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PH_W  = TONE_W - 8;

   localparam logic [7:0] TBL [32] = '{
      8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04,
      8'h06, 8'h07, 8'h09, 8'h0A, 8'h0C, 8'h0E, 8'h11, 8'h13,
      8'h17, 8'h1B, 8'h20, 8'h25, 8'h2C, 8'h35, 8'h3E, 8'h47,
      8'h54, 8'h66, 8'h77, 8'h88, 8'hA1, 8'hC0, 8'hE0, 8'hFF
   };

   typedef enum logic [1:0] {RUN_UP, RUN_DOWN, HOLD_LO, HOLD_HI} env_t;

   logic                        r_bdir;
   logic [7:0]                  r_addr;
   logic                        w_stb;
   logic                        w_wr;
   logic [DIV_W-1:0]            r_div;
   logic                        r_nphase;
   logic                        w_tick;
   logic                        w_ntick;
   logic [4:0]                  r_nper;
   logic                        r_mute;
   logic [4:0]                  r_ncnt;
   logic [4:0]                  w_nmax;
   logic [16:0]                 r_lfsr;
   logic [CHANNELS-1:0][7:0]    w_ch_rd;
   logic [CHANNELS-1:0]         w_hit;
   logic [MIX_W-1:0]            w_sum;
   logic [MIX_W-1:0]            r_mix;

   // A bus cycle is the rising edge of BDIR, seen against its registered copy.
   assign w_stb = BDIR & ~r_bdir;
   assign w_wr  = w_stb & ~BC;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_bdir <= 1'b0;
         r_addr <= 8'h00;
         r_nper <= 5'd0;
         r_mute <= 1'b0;
      end else begin
         r_bdir <= BDIR;
         if (w_stb && BC) r_addr <= DI;
         if (w_wr && r_addr == 8'hF0) r_nper <= DI[4:0];
         if (w_wr && r_addr == 8'hF1) r_mute <= DI[0];
      end
   end

   assign w_tick  = CE && (r_div == DIV_W'(DIV - 1));
   assign w_ntick = w_tick & r_nphase;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_div    <= '0;
         r_nphase <= 1'b0;
      end else if (CE) begin
         r_div <= w_tick ? '0 : r_div + DIV_W'(1);
         if (w_tick) r_nphase <= ~r_nphase;
      end
   end

   assign w_nmax = (r_nper == 5'd0) ? 5'd0 : r_nper - 5'd1;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_ncnt <= 5'd0;
         r_lfsr <= 17'h00001;
      end else if (w_ntick) begin
         if (r_ncnt >= w_nmax) begin
            r_ncnt <= 5'd0;
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
         end else begin
            r_ncnt <= r_ncnt + 5'd1;
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic              w_sel;
      logic              w_we;
      logic [TONE_W-1:0] r_per;
      logic [TONE_W-1:0] r_tcnt;
      logic [TONE_W-1:0] w_tmax;
      logic              r_tone;
      logic [4:0]        r_vol;
      logic [1:0]        r_mixr;
      logic [15:0]       r_eper;
      logic [15:0]       r_ecnt;
      logic [15:0]       w_emax;
      logic [3:0]        r_shape;
      logic              r_erst;
      logic              w_restart;
      logic              w_estep;
      env_t              r_est;
      env_t              w_est_nxt;
      logic [4:0]        r_evol;
      logic [4:0]        w_evol_nxt;
      logic              w_gate;
      logic [7:0]        w_rd;

      assign w_sel     = (r_addr[7:3] == 5'(c));
      assign w_we      = w_wr & w_sel;
      assign w_hit[c]  = w_sel;

      // A shape write arms a restart that the next CE consumes; a write in that same cycle re-arms it.
      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            r_per   <= '0;
            r_vol   <= 5'd0;
            r_mixr  <= 2'b11;
            r_eper  <= 16'd0;
            r_shape <= 4'd0;
            r_erst  <= 1'b0;
         end else begin
            if (CE) r_erst <= 1'b0;
            if (w_we) begin
               case (r_addr[2:0])
                  3'd0: r_per[7:0]        <= DI;
                  3'd1: r_per[TONE_W-1:8] <= DI[PH_W-1:0];
                  3'd2: r_vol             <= DI[4:0];
                  3'd3: r_mixr            <= DI[1:0];
                  3'd4: r_eper[7:0]       <= DI;
                  3'd5: r_eper[15:8]      <= DI;
                  3'd6: begin
                     r_shape <= DI[3:0];
                     r_erst  <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end

      always_comb begin
         w_rd = 8'h00;
         case (r_addr[2:0])
            3'd0:    w_rd = r_per[7:0];
            3'd1:    w_rd = 8'(r_per[TONE_W-1:8]);
            3'd2:    w_rd = {3'b000, r_vol};
            3'd3:    w_rd = {6'b000000, r_mixr};
            3'd4:    w_rd = r_eper[7:0];
            3'd5:    w_rd = r_eper[15:8];
            3'd6:    w_rd = {4'b0000, r_shape};
            default: w_rd = 8'h00;
         endcase
      end
      assign w_ch_rd[c] = w_rd;

      assign w_tmax = (r_per == '0) ? '0 : r_per - TONE_W'(1);

      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            r_tcnt <= '0;
            r_tone <= 1'b0;
         end else if (w_tick) begin
            if (r_tcnt >= w_tmax) begin
               r_tcnt <= '0;
               r_tone <= ~r_tone;
            end else begin
               r_tcnt <= r_tcnt + TONE_W'(1);
            end
         end
      end

      assign w_emax    = (r_eper == 16'd0) ? 16'd0 : r_eper - 16'd1;
      assign w_restart = CE & r_erst;
      assign w_estep   = w_tick && (r_ecnt >= w_emax);

      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            r_ecnt <= 16'd0;
         end else if (w_restart) begin
            r_ecnt <= 16'd0;
         end else if (w_tick) begin
            r_ecnt <= (r_ecnt >= w_emax) ? 16'd0 : r_ecnt + 16'd1;
         end
      end

      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            r_est  <= HOLD_LO;
            r_evol <= 5'd0;
         end else begin
            r_est  <= w_est_nxt;
            r_evol <= w_evol_nxt;
         end
      end

      // shape bits: [3]=C, [2]=At, [1]=Al, [0]=H; restart has priority over a coincident step.
      always_comb begin
         w_est_nxt  = r_est;
         w_evol_nxt = r_evol;
         if (w_restart) begin
            w_est_nxt  = r_shape[2] ? RUN_UP : RUN_DOWN;
            w_evol_nxt = r_shape[2] ? 5'd0 : 5'd31;
         end else if (w_estep) begin
            case (r_est)
               RUN_UP: begin
                  if (r_evol != 5'd31) begin
                     w_evol_nxt = r_evol + 5'd1;
                  end else if (!r_shape[3]) begin
                     w_est_nxt  = HOLD_LO;
                     w_evol_nxt = 5'd0;
                  end else if (r_shape[0]) begin
                     w_est_nxt  = r_shape[1] ? HOLD_LO : HOLD_HI;
                     w_evol_nxt = r_shape[1] ? 5'd0 : 5'd31;
                  end else if (r_shape[1]) begin
                     w_est_nxt = RUN_DOWN;
                  end else begin
                     w_evol_nxt = 5'd0;
                  end
               end
               RUN_DOWN: begin
                  if (r_evol != 5'd0) begin
                     w_evol_nxt = r_evol - 5'd1;
                  end else if (!r_shape[3]) begin
                     w_est_nxt  = HOLD_LO;
                     w_evol_nxt = 5'd0;
                  end else if (r_shape[0]) begin
                     w_est_nxt  = r_shape[1] ? HOLD_HI : HOLD_LO;
                     w_evol_nxt = r_shape[1] ? 5'd31 : 5'd0;
                  end else if (r_shape[1]) begin
                     w_est_nxt = RUN_UP;
                  end else begin
                     w_evol_nxt = 5'd31;
                  end
               end
               default: ;
            endcase
         end
      end

      assign w_gate = (r_mixr[0] | r_tone) & (r_mixr[1] | r_lfsr[0]);
      assign LEVEL[5*c +: 5] = !w_gate   ? 5'd0 :
                               r_vol[4]  ? r_evol :
                                           {r_vol[3:0], r_vol[3]};
   end

   always_comb begin
      DO = 8'h00;
      if (r_addr == 8'hF0) begin
         DO = {3'b000, r_nper};
      end else if (r_addr == 8'hF1) begin
         DO = {7'b0000000, r_mute};
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (w_hit[c]) DO = w_ch_rd[c];
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_sum = w_sum + MIX_W'(TBL[LEVEL[5*c +: 5]]);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_mix <= '0;
      else if (CE)  r_mix <= r_mute ? '0 : w_sum;
   end

   assign MIX = r_mix;

endmodule

// File: tb/tb_psg_multi.sv
// Directed bench for psg_multi: a 3-channel and an 8-channel instance share one bus.
module tb_psg_multi;
   localparam int DIV = 8;

   localparam logic [7:0] TBL [32] = '{
      8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04,
      8'h06, 8'h07, 8'h09, 8'h0A, 8'h0C, 8'h0E, 8'h11, 8'h13,
      8'h17, 8'h1B, 8'h20, 8'h25, 8'h2C, 8'h35, 8'h3E, 8'h47,
      8'h54, 8'h66, 8'h77, 8'h88, 8'hA1, 8'hC0, 8'hE0, 8'hFF
   };

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce    = 1'b0;
   logic        bdir  = 1'b0;
   logic        bc    = 1'b0;
   logic [7:0]  di    = 8'h00;
   logic [7:0]  do0, do1;
   logic [14:0] lvl0;
   logic [39:0] lvl1;
   logic [9:0]  mix0;
   logic [10:0] mix1;

   psg_multi #(.CHANNELS(3), .TONE_W(12), .DIV(DIV)) u0 (
      .CLK(clk), .RESET_N(rst_n), .CE(ce), .BDIR(bdir), .BC(bc), .DI(di),
      .DO(do0), .LEVEL(lvl0), .MIX(mix0));

   psg_multi #(.CHANNELS(8), .TONE_W(12), .DIV(DIV)) u1 (
      .CLK(clk), .RESET_N(rst_n), .CE(ce), .BDIR(bdir), .BC(bc), .DI(di),
      .DO(do1), .LEVEL(lvl1), .MIX(mix1));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q[$];
   int          iv_q[$];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input logic [63:0] v);
      exp_q.push_back(v);
   endtask

   task automatic expect_chg(input logic [63:0] v, input int iv);
      exp_q.push_back(v);
      iv_q.push_back(iv);
   endtask

   task automatic sb_check(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
         end
      end
   endtask

   task automatic bus(input logic a, input logic [7:0] d);
      bc = a; di = d; bdir = 1'b1;
      @(posedge clk); #1;
      bdir = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus(1'b1, a);
      bus(1'b0, d);
   endtask

   task automatic rd(input logic [7:0] a);
      bus(1'b1, a);
   endtask

   task automatic wait_level(input string tag, input int ch, input logic [4:0] v, input int budget);
      int cyc;
      cyc = 0;
      while (lvl0[5*ch +: 5] !== v && cyc < budget) begin
         step(1);
         cyc++;
      end
      checks++;
      assert (cyc < budget) else begin
         errors++;
         $error("FAIL %s wait: cycles=%0d limit=%0d", tag, cyc, budget);
      end
   endtask

   // Each change of the channel level pops one expected value and one expected spacing (-1 = unchecked).
   task automatic track(input string tag, input int ch, input int n, input int budget);
      logic [4:0] prev;
      int cyc, last, iv;
      prev = lvl0[5*ch +: 5];
      cyc  = 0;
      last = 0;
      for (int k = 0; k < n; k++) begin
         while (lvl0[5*ch +: 5] === prev && cyc < budget) begin
            step(1);
            cyc++;
         end
         checks++;
         assert (cyc < budget) else begin
            errors++;
            $error("FAIL %s timeout: cycles=%0d limit=%0d", tag, cyc, budget);
         end
         if (cyc >= budget) begin
            exp_q.delete();
            iv_q.delete();
            return;
         end
         prev = lvl0[5*ch +: 5];
         sb_check(tag, 64'(prev));
         iv = iv_q.pop_front();
         if (iv >= 0) chk({tag, "_interval"}, 64'(cyc - last), 64'(iv));
         last = cyc;
      end
   endtask

   initial begin
      // Reset state
      step(3);
      chk("rst_level0", 64'(lvl0), 64'd0);
      chk("rst_mix0", 64'(mix0), 64'd0);
      chk("rst_do0", 64'(do0), 64'd0);
      chk("rst_mix1", 64'(mix1), 64'd0);
      rst_n = 1'b1;
      ce    = 1'b1;
      step(2);
      chk("idle_mix0", 64'(mix0), 64'd0);

      for (int a = 0; a < 24; a++) begin
         expect_val((a % 8 == 3) ? 64'h03 : 64'h00);
         rd(8'(a));
         sb_check("rd_reset", 64'(do0));
      end
      expect_val(64'h00); rd(8'hF0); sb_check("rd_noise_per", 64'(do0));
      expect_val(64'h00); rd(8'hF1); sb_check("rd_mute", 64'(do0));
      rd(8'h3B);
      chk("rd_u0_unmapped_3b", 64'(do0), 64'h00);
      chk("rd_u1_ch7_mix", 64'(do1), 64'h03);

      // Ch0 tone, P=2: 16-clock half periods, MIX one clock behind LEVEL
      wr(8'h00, 8'h02);
      wr(8'h03, 8'h02);
      wr(8'h02, 8'h0F);
      wait_level("tone_p2", 0, 5'd0, 100);
      expect_chg(64'd31, -1);
      for (int k = 0; k < 4; k++) expect_chg((k % 2 == 0) ? 64'd0 : 64'd31, 16);
      track("tone_p2", 0, 5, 200);
      for (int k = 0; k < 36; k++) begin
         expect_val(64'(TBL[lvl0[4:0]]));
         step(1);
         sb_check("mix_follow", 64'(mix0));
      end

      // Period 0 acts as period 1
      wr(8'h00, 8'h00);
      wait_level("tone_p0", 0, 5'd0, 100);
      expect_chg(64'd31, -1);
      expect_chg(64'd0, 8);
      expect_chg(64'd31, 8);
      track("tone_p0", 0, 3, 100);

      // Ch1 envelope, E=1, shape 0xD: ramp up then hold high
      wr(8'h0C, 8'h01);
      wr(8'h0A, 8'h10);
      wr(8'h0E, 8'h0D);
      chk("env_start", 64'(lvl0[9:5]), 64'd0);
      for (int v = 1; v <= 31; v++) expect_chg(64'(v), (v == 1) ? -1 : DIV);
      track("env_up", 1, 31, 400);
      step(40);
      chk("env_hold_hi", 64'(lvl0[9:5]), 64'd31);
      wr(8'h0E, 8'h0D);
      chk("env_rewrite", 64'(lvl0[9:5]), 64'd0);
      for (int v = 1; v <= 3; v++) expect_chg(64'(v), (v == 1) ? -1 : DIV);
      track("env_again", 1, 3, 100);

      // CE=0 freezes sound state but bus writes land; restart waits for CE
      ce = 1'b0;
      step(20);
      chk("ce0_hold", 64'(lvl0[9:5]), 64'd3);
      wr(8'hF0, 8'h1F);
      expect_val(64'h1F); rd(8'hF0); sb_check("ce0_write", 64'(do0));
      wr(8'h0E, 8'h0D);
      chk("ce0_restart_pending", 64'(lvl0[9:5]), 64'd3);
      ce = 1'b1;
      step(1);
      chk("restart_on_ce", 64'(lvl0[9:5]), 64'd0);

      // Ch2 triangle, shape 0xA: each end value held one extra step
      wr(8'h14, 8'h01);
      wr(8'h12, 8'h10);
      wr(8'h16, 8'h0A);
      chk("tri_start", 64'(lvl0[14:10]), 64'd31);
      for (int v = 30; v >= 0; v--) expect_chg(64'(v), (v == 30) ? -1 : DIV);
      expect_chg(64'd1, 2 * DIV);
      for (int v = 2; v <= 31; v++) expect_chg(64'(v), DIV);
      expect_chg(64'd30, 2 * DIV);
      track("tri", 2, 63, 800);

      // Read-back masking and unmapped addresses
      wr(8'h11, 8'hFF);
      expect_val(64'h0F); rd(8'h11); sb_check("rd_per_hi_mask", 64'(do0));
      wr(8'h15, 8'hAB);
      expect_val(64'hAB); rd(8'h15); sb_check("rd_eper_hi", 64'(do0));
      expect_val(64'h10); rd(8'h12); sb_check("rd_vol", 64'(do0));
      wr(8'h17, 8'hFF);
      expect_val(64'h00); rd(8'h17); sb_check("rd_reserved", 64'(do0));
      wr(8'hC0, 8'h55);
      rd(8'hC0);
      chk("rd_c0_u0", 64'(do0), 64'h00);
      chk("rd_c0_u1", 64'(do1), 64'h00);
      expect_val(64'h00); rd(8'h00); sb_check("c0_no_alias", 64'(do0));

      // Asynchronous reset mid-envelope
      expect_val(64'h02); rd(8'h03); sb_check("rd_ch0_mix", 64'(do0));
      rst_n = 1'b0;
      #2;
      chk("arst_level0", 64'(lvl0), 64'd0);
      chk("arst_mix0", 64'(mix0), 64'd0);
      chk("arst_do0", 64'(do0), 64'd0);
      chk("arst_level1", 64'(lvl1), 64'd0);
      chk("arst_mix1", 64'(mix1), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1);

      // Eight channels at full level, then mute
      for (int c = 0; c < 8; c++) wr(8'(8 * c + 2), 8'h0F);
      step(2);
      chk("full_level1", 64'(lvl1), 64'hFF_FFFF_FFFF);
      chk("full_mix1", 64'(mix1), 64'h7F8);
      chk("full_mix0", 64'(mix0), 64'h2FD);
      bus(1'b1, 8'hF1);
      bc = 1'b0; di = 8'h01; bdir = 1'b1;
      @(posedge clk); #1;
      chk("mute_write_cycle", 64'(mix1), 64'h7F8);
      bdir = 1'b0;
      @(posedge clk); #1;
      chk("mute_mix1", 64'(mix1), 64'd0);
      chk("mute_mix0", 64'(mix0), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/psg_multi.md
# psg_multi

Parametrised programmable sound generator and successor to the 3-channel YM-style PSG in the arcade audio path. It provides CHANNELS square-wave tone channels, a shared 17-bit noise generator and one envelope generator per channel instead of a single shared one. Each channel's 5-bit level is mapped through a 32-entry logarithmic table, and all channels are summed into one registered mono sample. It sits on the CPU sound bus with the same BDIR/BC latch-then-write protocol as the existing PSG.

## Interface
- CHANNELS, 3: number of tone channels, 1..8.
- TONE_W, 12: tone period width, 9..16.
- DIV, 8: CE pulses per tone/envelope tick; the noise tick is every 2*DIV CE pulses.
- Derived: MIX_W = 8 + clog2(CHANNELS).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CE  in  1  PSG clock enable.
- BDIR  in  1  bus direction; its rising edge strobes a bus cycle.
- BC  in  1  1 = address latch, 0 = data write.
- DI  in  8  bus data in.
- DO  out  8  read data for the latched address.
- LEVEL  out  5*CHANNELS  per-channel 5-bit level; channel c occupies bits [5c+4:5c].
- MIX  out  MIX_W  registered sum of table[LEVEL[c]] over all channels.

## Operation
- Register map, channel c at base 8c for c < CHANNELS:
  - +0: period[7:0].
  - +1: period[TONE_W-1:8].
  - +2: volume. Bit4 = envelope mode; bits3:0 = fixed level.
  - +3: mix. Bit0 = tone disable; bit1 = noise disable.
  - +4 / +5: envelope period, low / high byte.
  - +6: envelope shape [3:0] as C/At/Al/H. A write restarts the envelope.
  - +7: reserved; reads 0.
- Global registers:
  - 0xF0: noise period [4:0].
  - 0xF1: bit0 = mute, which forces MIX to 0.
- Unmapped addresses: writes are ignored and reads return 0. Unused register bits read 0.
- Bus: the rising edge of BDIR is detected from a registered copy of BDIR. On that edge, BC=1 latches DI into addr; BC=0 writes DI to reg[addr]. DO is combinational from reg[addr].
- Divider: counts CE pulses. It emits tick every DIV pulses and ntick on every second tick.
- Tone counters:
  - On tick: if cnt >= max(P,1)-1, cnt is cleared and the tone output toggles; otherwise cnt increments.
  - The >= comparison means a smaller period written mid-count wraps on the next tick.
- Noise: on ntick, the noise counter runs the same compare against max(N,1)-1. On wrap, lfsr = {lfsr[0]^lfsr[3], lfsr[16:1]}. Noise output is lfsr[0].
- Gate per channel: gate = (tone_dis | tone) & (noise_dis | noise).
- Level per channel:
  - gate=0: level is 0.
  - gate=1, envelope mode: level is env_vol.
  - gate=1, fixed mode: level is {vol[3:0], vol[3]}.
- Envelope: one FSM per channel with states RUN_UP, RUN_DOWN, HOLD_LO, HOLD_HI, and a 16-bit period counter using the same compare rule as the tone counters.
  - Restart: At=1 loads env_vol=0 and RUN_UP; At=0 loads env_vol=31 and RUN_DOWN.
  - A step occurs on each envelope wrap.
  - RUN_UP at 31:
    - C=0 goes to HOLD_LO with env_vol=0.
    - H=1 and Al=0 goes to HOLD_HI.
    - H=1 and Al=1 goes to HOLD_LO with env_vol=0.
    - Al=1 and H=0 goes to RUN_DOWN.
    - Otherwise env_vol wraps to 0.
  - RUN_DOWN at 0: the same rules apply with up and down swapped, and with HOLD_HI/HOLD_LO and 31/0 swapped.
  - C=0 always ends in HOLD_LO at 0.
- Mix: MIX is registered on every CE as the sum of the table values, or 0 when muted. The table is the 32-entry YM curve from 0x00 to 0xFF (0,1,1,2,2,3,3,4,6,7,9,0A,0C,0E,11,13,17,1B,20,25,2C,35,3E,47,54,66,77,88,A1,C0,E0,FF).

## Timing
- Reset state:
  - All registers 0 except mix regs, which reset to 0x03 (all sources disabled).
  - addr=0, counters 0, tone outputs 0, lfsr=17'h00001.
  - env_vol=0 in HOLD_LO.
  - DO=0, LEVEL=0, MIX=0.
- Reset is fully asynchronous: asserting it mid-note returns the block to the reset state immediately.
- A register write takes effect in the cycle after the BDIR rising edge.
- An envelope restart is applied on the first CE after the shape write. If an envelope step falls in the same cycle, the restart wins.
- LEVEL is combinational from state. MIX follows LEVEL by one CE.
- Tone period: the output has a period of 2*max(P,1)*DIV CE pulses.
- Envelope step: one step every max(E,1)*DIV CE pulses.
- All counters advance only on CE. When CE=0 the block holds its state, but bus writes still occur.

## Test plan
- Reset, then read every mapped address: all return 0 except mix regs, which return 0x03. MIX=0.
- Ch0 with P=2, tone enabled, fixed volume 0xF, CE always 1, DIV=8: LEVEL0 toggles between 31 and 0 every 16 clocks, and MIX toggles between 0xFF and 0 one clock later.
- Ch1, envelope mode, E=1, shape 0xD: env_vol ramps 0→31, one step per 8 CE pulses, then holds at 31. Writing shape 0xD again restarts the ramp at 0.
- Shape 0xA: triangle 31→0→31; the level at 0 and at 31 is each held for exactly one step.
- All channels at fixed volume 0xF with CHANNELS=8: MIX=0x7F8 with no overflow. Setting mute gives MIX=0 on the next CE.
- Bus checks:
  - Write to address 0xC0 with CHANNELS=3: ignored, and reads 0.
  - Pulse RESET_N low mid-envelope: all outputs are 0 at once.
  - Period 0: behaves as period 1.
